// File: rtl/sample_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sample_bist_ctrl
// Description : Sweeps all 16 {x,y,z,w} vectors into the sample function,
//               compares f_in against the reference, reports mismatches.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_bist_ctrl #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       x,
    output logic       y,
    output logic       z,
    output logic       w,
    input  logic       f_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] fail_vec,
    output logic       fail_valid
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_settle = 2'd1;
    localparam logic [1:0] c_st_check  = 2'd2;
    localparam logic [1:0] c_st_done   = 2'd3;

    localparam logic [3:0] c_settle_last = 4'(SETTLE_CYCLES - 1);
    localparam logic [4:0] c_err_max     = 5'd16;

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic [3:0] r_vec;
    logic [3:0] r_cnt;
    logic [4:0] r_err_count;
    logic [3:0] r_fail_vec;
    logic       r_fail_valid;
    logic       r_pass;

    logic       w_expected;
    logic       w_mismatch;
    logic [4:0] w_err_next;

    // Reference model of the sample function
    assign w_expected = (r_vec[3] ^ (r_vec[2] & r_vec[1])) | ~r_vec[0];
    assign w_mismatch = f_in ^ w_expected;
    assign w_err_next = (w_mismatch && (r_err_count != c_err_max))
                        ? r_err_count + 5'd1 : r_err_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_state_next = c_st_settle;
                end
            end
            c_st_settle: begin
                if (r_cnt == c_settle_last) begin
                    w_state_next = c_st_check;
                end
            end
            c_st_check: begin
                w_state_next = (r_vec == 4'd15) ? c_st_done : c_st_settle;
            end
            c_st_done: begin
                w_state_next = c_st_idle;
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec        <= 4'd0;
            r_cnt        <= 4'd0;
            r_err_count  <= 5'd0;
            r_fail_vec   <= 4'd0;
            r_fail_valid <= 1'b0;
            r_pass       <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_vec        <= 4'd0;
                        r_cnt        <= 4'd0;
                        r_err_count  <= 5'd0;
                        r_fail_vec   <= 4'd0;
                        r_fail_valid <= 1'b0;
                        r_pass       <= 1'b0;
                    end
                end
                c_st_settle: begin
                    r_cnt <= (r_cnt == c_settle_last) ? 4'd0 : r_cnt + 4'd1;
                end
                c_st_check: begin
                    r_err_count <= w_err_next;
                    // Only the first failing vector of a sweep is kept
                    if (w_mismatch && !r_fail_valid) begin
                        r_fail_vec   <= r_vec;
                        r_fail_valid <= 1'b1;
                    end
                    if (r_vec != 4'd15) begin
                        r_vec <= r_vec + 4'd1;
                    end else begin
                        r_pass <= (w_err_next == 5'd0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign x          = r_vec[3];
    assign y          = r_vec[2];
    assign z          = r_vec[1];
    assign w          = r_vec[0];
    assign busy       = (r_state != c_st_idle);
    assign done       = (r_state == c_st_done);
    assign pass       = r_pass;
    assign err_count  = r_err_count;
    assign fail_vec   = r_fail_vec;
    assign fail_valid = r_fail_valid;

endmodule
`default_nettype wire

// File: tb/tb_sample_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sample_bist_ctrl
// Description : Directed self-checking bench for sample_bist_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sample_bist_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start0, start1;
    logic [1:0] mode;  // 0 correct, 1 inverted, 2 wrong only at vector 5

    logic       x0, y0, z0, w0, f0, busy0, done0, pass0, fval0;
    logic [4:0] err0;
    logic [3:0] fvec0;
    logic       x1, y1, z1, w1, f1, busy1, done1, pass1, fval1;
    logic [4:0] err1;
    logic [3:0] fvec1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic golden(input logic [3:0] v);
        return (v[3] ^ (v[2] & v[1])) | ~v[0];
    endfunction

    function automatic logic stim_f(input logic [3:0] v, input logic [1:0] m);
        return golden(v) ^ (m == 2'd1) ^ ((m == 2'd2) && (v == 4'd5));
    endfunction

    assign f0 = stim_f({x0, y0, z0, w0}, mode);
    assign f1 = stim_f({x1, y1, z1, w1}, mode);

    sample_bist_ctrl dut0 (
        .clk(clk), .rst(rst), .start(start0),
        .x(x0), .y(y0), .z(z0), .w(w0), .f_in(f0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .fail_vec(fvec0), .fail_valid(fval0)
    );

    sample_bist_ctrl #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .x(x1), .y(y1), .z(z1), .w(w1), .f_in(f1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_vec(fvec1), .fail_valid(fval1)
    );

    // Pulses start into one instance and observes the sweep for a fixed window.
    // Cycle 1 is the cycle following the edge that samples start.
    task automatic run_sweep(input bit which, input int window, input bit poke,
                             output int done_cyc, output int n_done,
                             output logic pass_at_done);
        logic d;
        done_cyc = -1;
        n_done = 0;
        pass_at_done = 1'bx;
        @(negedge clk);
        if (which) start1 = 1'b1; else start0 = 1'b1;
        for (int n = 1; n <= window; n++) begin
            @(negedge clk);
            start0 = 1'b0;
            start1 = 1'b0;
            d = which ? done1 : done0;
            if (d === 1'b1) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc = n;
                    pass_at_done = which ? pass1 : pass0;
                end
            end
            if (poke && !which && (({x0, y0, z0, w0} == 4'd3) || done0 === 1'b1))
                start0 = 1'b1;
        end
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        mode = 2'd0;
        repeat (3) @(negedge clk);
        n_cmp++; if ({x0, y0, z0, w0} !== 4'd0) begin n_err++; $display("FAIL reset_vec: got %0d expected 0", {x0, y0, z0, w0}); end
        n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy0); end
        n_cmp++; if (done0 !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done0); end
        n_cmp++; if (pass0 !== 1'b0) begin n_err++; $display("FAIL reset_pass: got %b expected 0", pass0); end
        n_cmp++; if (err0 !== 5'd0) begin n_err++; $display("FAIL reset_err: got %0d expected 0", err0); end
        n_cmp++; if (fvec0 !== 4'd0 || fval0 !== 1'b0) begin n_err++; $display("FAIL reset_fail: got vec %0d valid %b expected 0 0", fvec0, fval0); end
        n_cmp++; if (busy1 !== 1'b0 || {x1, y1, z1, w1} !== 4'd0) begin n_err++; $display("FAIL reset_dut1: got busy %b vec %0d expected 0 0", busy1, {x1, y1, z1, w1}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_clean_sweep();
        int dc, nd;
        logic pd;
        mode = 2'd0;
        run_sweep(1'b0, 60, 1'b0, dc, nd, pd);
        n_cmp++; if (dc != 49) begin n_err++; $display("FAIL clean_done_cycle: got %0d expected 49", dc); end
        n_cmp++; if (nd != 1) begin n_err++; $display("FAIL clean_done_pulses: got %0d expected 1", nd); end
        n_cmp++; if (pd !== 1'b1) begin n_err++; $display("FAIL clean_pass_at_done: got %b expected 1", pd); end
        n_cmp++; if (err0 !== 5'd0 || fval0 !== 1'b0) begin n_err++; $display("FAIL clean_errs: got err %0d valid %b expected 0 0", err0, fval0); end
        n_cmp++; if (pass0 !== 1'b1 || busy0 !== 1'b0) begin n_err++; $display("FAIL clean_hold: got pass %b busy %b expected 1 0", pass0, busy0); end
        n_cmp++; if ({x0, y0, z0, w0} !== 4'd15) begin n_err++; $display("FAIL clean_vec_hold: got %0d expected 15", {x0, y0, z0, w0}); end
    endtask

    task automatic test_inverted();
        int dc, nd;
        logic pd;
        mode = 2'd1;
        run_sweep(1'b0, 60, 1'b0, dc, nd, pd);
        n_cmp++; if (dc != 49 || pd !== 1'b0) begin n_err++; $display("FAIL inv_done: got cycle %0d pass %b expected 49 0", dc, pd); end
        n_cmp++; if (err0 !== 5'd16) begin n_err++; $display("FAIL inv_err: got %0d expected 16", err0); end
        n_cmp++; if (fvec0 !== 4'd0 || fval0 !== 1'b1) begin n_err++; $display("FAIL inv_fail: got vec %0d valid %b expected 0 1", fvec0, fval0); end
        n_cmp++; if (pass0 !== 1'b0) begin n_err++; $display("FAIL inv_pass: got %b expected 0", pass0); end
    endtask

    task automatic test_single_fault();
        int dc, nd;
        logic pd;
        mode = 2'd2;
        run_sweep(1'b0, 60, 1'b0, dc, nd, pd);
        n_cmp++; if (err0 !== 5'd1) begin n_err++; $display("FAIL single_err: got %0d expected 1", err0); end
        n_cmp++; if (fvec0 !== 4'd5 || fval0 !== 1'b1) begin n_err++; $display("FAIL single_fail: got vec %0d valid %b expected 5 1", fvec0, fval0); end
        n_cmp++; if (pass0 !== 1'b0 || pd !== 1'b0) begin n_err++; $display("FAIL single_pass: got %b/%b expected 0/0", pass0, pd); end
    endtask

    task automatic test_back_to_back();
        int dc, nd;
        logic pd;
        mode = 2'd0;
        run_sweep(1'b0, 70, 1'b1, dc, nd, pd);
        n_cmp++; if (dc != 49) begin n_err++; $display("FAIL b2b_done_cycle: got %0d expected 49", dc); end
        n_cmp++; if (nd != 1) begin n_err++; $display("FAIL b2b_done_pulses: got %0d expected 1", nd); end
        n_cmp++; if (busy0 !== 1'b0 || {x0, y0, z0, w0} !== 4'd15) begin n_err++; $display("FAIL b2b_no_restart: got busy %b vec %0d expected 0 15", busy0, {x0, y0, z0, w0}); end
        n_cmp++; if (pass0 !== 1'b1 || err0 !== 5'd0) begin n_err++; $display("FAIL b2b_result: got pass %b err %0d expected 1 0", pass0, err0); end
    endtask

    task automatic test_reset_midsweep();
        int dc, nd, k;
        logic pd;
        mode = 2'd1;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        k = 0;
        while ({x0, y0, z0, w0} != 4'd7 && k < 100) begin
            @(negedge clk);
            k++;
        end
        n_cmp++; if (k >= 100 || busy0 !== 1'b1 || fval0 !== 1'b1) begin n_err++; $display("FAIL mid_reach_vec7: got waited %0d busy %b valid %b expected <100 1 1", k, busy0, fval0); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy0 !== 1'b0 || {x0, y0, z0, w0} !== 4'd0) begin n_err++; $display("FAIL mid_rst_state: got busy %b vec %0d expected 0 0", busy0, {x0, y0, z0, w0}); end
        n_cmp++; if (err0 !== 5'd0 || fvec0 !== 4'd0 || fval0 !== 1'b0 || pass0 !== 1'b0 || done0 !== 1'b0) begin
            n_err++; $display("FAIL mid_rst_results: got err %0d vec %0d valid %b pass %b done %b expected all 0", err0, fvec0, fval0, pass0, done0);
        end
        nd = 0;
        repeat (3) begin
            @(negedge clk);
            if (done0 === 1'b1) nd++;
        end
        n_cmp++; if (nd != 0) begin n_err++; $display("FAIL mid_rst_no_done: got %0d pulses expected 0", nd); end
        rst = 1'b0;
        mode = 2'd0;
        run_sweep(1'b0, 60, 1'b0, dc, nd, pd);
        n_cmp++; if (dc != 49 || pd !== 1'b1 || err0 !== 5'd0) begin n_err++; $display("FAIL mid_rerun: got cycle %0d pass %b err %0d expected 49 1 0", dc, pd, err0); end
    endtask

    task automatic test_settle1();
        int dc, nd;
        logic pd;
        mode = 2'd0;
        run_sweep(1'b1, 45, 1'b0, dc, nd, pd);
        n_cmp++; if (dc != 33) begin n_err++; $display("FAIL s1_done_cycle: got %0d expected 33", dc); end
        n_cmp++; if (pd !== 1'b1 || pass1 !== 1'b1 || err1 !== 5'd0) begin n_err++; $display("FAIL s1_result: got pass %b/%b err %0d expected 1/1 0", pd, pass1, err1); end
        n_cmp++; if (nd != 1 || busy1 !== 1'b0) begin n_err++; $display("FAIL s1_idle: got pulses %0d busy %b expected 1 0", nd, busy1); end
    endtask

    initial begin
        test_reset();
        test_clean_sweep();
        test_inverted();
        test_single_fault();
        test_back_to_back();
        test_reset_midsweep();
        test_settle1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sample_bist_ctrl.md
SAMPLE_BIST_CTRL -- requirements
Module: sample_bist_ctrl

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 2, meaning cycles each vector is held before f is sampled (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, request to run a full 16-vector sweep.
REQ-005 The block SHALL have ports x, y, z, w, output, 1 each, registered stimulus driven to the sample function instance.
REQ-006 The block SHALL have port f_in, input, 1, the sample function result under test.
REQ-007 The block SHALL have port busy, output, 1, high while a sweep is in progress.
REQ-008 The block SHALL have port done, output, 1, one-cycle pulse when a sweep completes.
REQ-009 The block SHALL have port pass, output, 1, high when the last completed sweep had zero mismatches.
REQ-010 The block SHALL have port err_count, output, 5, number of mismatching vectors in the current or last sweep (0..16).
REQ-011 The block SHALL have port fail_vec, output, 4, index of the first mismatching vector.
REQ-012 The block SHALL have port fail_valid, output, 1, high when fail_vec holds a captured index.

Function
REQ-013 The block SHALL hold a 4-bit vector register vec, with {x,y,z,w} = vec at all times (x = vec[3], w = vec[0]).
REQ-014 The block SHALL compute expected = (x XOR (y AND z)) OR (NOT w) from vec.
REQ-015 The block SHALL implement states IDLE, SETTLE, CHECK, DONE.
REQ-016 In IDLE, start=1 SHALL load vec=0, err_count=0, fail_valid=0, fail_vec=0, pass=0, the settle counter=0, and enter SETTLE.
REQ-017 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then enter CHECK.
REQ-018 CHECK SHALL last one cycle; if f_in differs from expected, err_count SHALL increment by 1.
REQ-019 On the first mismatch of a sweep, CHECK SHALL capture fail_vec=vec and set fail_valid=1; later mismatches SHALL NOT overwrite them.
REQ-020 From CHECK with vec<15, the block SHALL increment vec and enter SETTLE; with vec=15 it SHALL enter DONE.
REQ-021 DONE SHALL last one cycle with done=1 and pass=(err_count==0); pass SHALL reflect the final CHECK's result; the block then enters IDLE.
REQ-022 busy SHALL be 1 in SETTLE, CHECK and DONE, and 0 in IDLE.
REQ-023 start SHALL be ignored outside IDLE, including in DONE.
REQ-024 After DONE, vec SHALL remain 15, and pass, err_count, fail_vec and fail_valid SHALL hold until the next accepted start or reset.
REQ-025 With start sampled high at edge 0, done SHALL be high in cycle 16*(SETTLE_CYCLES+1)+1.
REQ-026 err_count SHALL never wrap; 16 is its maximum reachable value.

Reset
REQ-027 rst=1 SHALL, at the next rising edge, force state=IDLE, vec=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0 and fail_valid=0.
REQ-028 rst SHALL take priority over start and over every state transition, including mid-sweep; no partial result is retained.
REQ-029 rst SHALL produce no done pulse.

Verification
REQ-030 A correct f_in with default SETTLE_CYCLES=2 and a start pulse SHALL give done in cycle 49 with pass=1, err_count=0 and fail_valid=0.
REQ-031 An inverted f_in (NOT expected) SHALL give err_count=16, fail_vec=0, fail_valid=1 and pass=0.
REQ-032 An f_in wrong only when vec=5 SHALL give err_count=1, fail_vec=5 and pass=0.
REQ-033 A start re-asserted at vector 3 and again in the DONE cycle SHALL be ignored; exactly one done pulse occurs, and no sweep restarts.
REQ-034 rst asserted while vec=7 SHALL give, the next cycle, busy=0, vec=0 and all result outputs 0; a following start SHALL run a full clean sweep.
REQ-035 With SETTLE_CYCLES=1 and a correct f_in, done SHALL occur in cycle 33 with pass=1.
